// File: rtl/vga_pixel_feeder.sv
// Pixel FIFO in front of the VGA driver. It holds the driver's counters at origin
// with sync code 2'b11 until the FIFO is primed, then drains one pixel per active clock.
module vga_pixel_feeder #(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic [5:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          sync_req,
  input  logic          de,
  output logic [7:0]    wb_data,
  output logic [LW-1:0] level,
  output logic          underrun,
  output logic          streaming
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {SYNC, STREAM} state_t;

  state_t        state, state_next;
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [7:0]    wb_next;
  logic          underrun_next;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign s_ready = !full;
  // A flush discards anything offered in the same cycle.
  assign push    = s_valid && s_ready && !sync_req;

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    wb_next       = 8'h00;
    underrun_next = underrun;
    if (sync_req) begin
      state_next    = SYNC;
      wb_next       = 8'h03;
      underrun_next = 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (level >= LW'(PRIME_LEVEL)) state_next = STREAM;
          else                            wb_next    = 8'h03;
        end
        STREAM: begin
          if (de) begin
            if (!empty) begin
              pop     = 1'b1;
              wb_next = {mem[rd_ptr], 2'b00};
            end else begin
              underrun_next = 1'b1;
            end
          end
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state     <= SYNC;
      streaming <= 1'b0;
      wb_data   <= 8'h03;
      underrun  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state     <= state_next;
      streaming <= (state_next == STREAM);
      wb_data   <= wb_next;
      underrun  <= underrun_next;
      if (sync_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // Storage is data only; pointers and level define what is valid.
  always_ff @(posedge clk_pix) begin
    if (rst_pix_n && push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: a queue of expected wb_data words is filled
// on accepted pushes and drained whenever a pop is due.
module tb_vga_pixel_feeder;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_pix = 1'b0;
  logic          rst_pix_n;
  logic [5:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          sync_req;
  logic          de;
  logic [7:0]    wb_data;
  logic [LW-1:0] level;
  logic          underrun;
  logic          streaming;

  vga_pixel_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sync_req(sync_req), .de(de), .wb_data(wb_data),
    .level(level), .underrun(underrun), .streaming(streaming)
  );

  always #5 clk_pix = ~clk_pix;

  int       npass = 0;
  int       ntot  = 0;
  logic [7:0] sb[$];
  bit       m_stream;
  bit       m_und;
  logic [7:0] m_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntot++;
    assert (obs === exp_v) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wb_data"},   32'(wb_data),   32'(m_wb));
    chk({tag, ".level"},     32'(level),     32'(sb.size()));
    chk({tag, ".underrun"},  32'(underrun),  32'(m_und));
    chk({tag, ".streaming"}, 32'(streaming), 32'(m_stream));
  endtask

  task automatic reset_cycle(input string tag);
    rst_pix_n = 1'b0; s_valid = 1'b1; s_data = 6'h3F; de = 1'b0; sync_req = 1'b0;
    @(posedge clk_pix); #1;
    sb.delete(); m_stream = 0; m_und = 0; m_wb = 8'h03;
    check_outputs(tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cycle(input string tag, input bit sv, input logic [5:0] d,
                       input bit de_i, input bit sr);
    bit push;
    rst_pix_n = 1'b1; s_valid = sv; s_data = d; de = de_i; sync_req = sr;
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(sb.size() < DEPTH));
    push = sv && (sb.size() < DEPTH) && !sr;
    if (sr) begin
      sb.delete(); m_und = 0; m_wb = 8'h03; m_stream = 0;
    end else if (!m_stream) begin
      if (sb.size() >= PRIME) begin m_stream = 1; m_wb = 8'h00; end
      else m_wb = 8'h03;
      if (push) sb.push_back({d, 2'b00});
    end else begin
      m_wb = 8'h00;
      if (de_i) begin
        if (sb.size() > 0) m_wb = sb.pop_front();
        else m_und = 1;
      end
      if (push) sb.push_back({d, 2'b00});
    end
    @(posedge clk_pix); #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_pix_n = 1'b0; s_valid = 1'b0; s_data = '0; de = 1'b0; sync_req = 1'b0;
    m_wb = 8'h03;
    @(negedge clk_pix);

    for (int i = 0; i < 3; i++) reset_cycle("reset");

    // Prime with 3F,01..07 while de=0, then one idle cycle to enter STREAM.
    cycle("prime", 1, 6'h3F, 0, 0);
    for (int i = 1; i < 8; i++) cycle("prime", 1, 6'(i), 0, 0);
    chk("prime.still_sync_wb", 32'(wb_data), 32'h03);
    cycle("prime_exit", 0, 6'h00, 0, 0);
    chk("prime.streaming", 32'(streaming), 32'd1);

    for (int i = 0; i < 8; i++) cycle("drain", 0, 6'h00, 1, 0);
    chk("drain.last", 32'(wb_data), 32'h1C);
    cycle("underrun", 0, 6'h00, 1, 0);
    chk("underrun.set", 32'(underrun), 32'd1);
    cycle("underrun_sticky", 0, 6'h00, 0, 0);

    // Fill to full, offer while full, pop once, let the held pixel in, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 6'((i * 5 + 3) & 6'h3F), 0, 0);
    chk("fill.full_ready", 32'(s_ready), 32'd0);
    cycle("held", 1, 6'h15, 0, 0);
    cycle("full_pop", 1, 6'h15, 1, 0);
    cycle("held_in", 1, 6'h15, 0, 0);
    chk("refill.level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle("order", 0, 6'h00, 1, 0);

    // Simultaneous push and pop at level 1.
    cycle("one", 1, 6'h11, 0, 0);
    cycle("simul", 1, 6'h2A, 1, 0);
    cycle("simul_out", 0, 6'h00, 1, 0);
    chk("simul.A8", 32'(wb_data), 32'hA8);

    // Mid-stream resync with a push that must be discarded.
    for (int i = 0; i < 5; i++) cycle("pre_sync", 1, 6'(i + 8), 0, 0);
    cycle("sync_req", 1, 6'h33, 1, 1);
    cycle("post_sync", 0, 6'h00, 1, 0);
    for (int i = 0; i < 3; i++) cycle("sync_no_pop", 1, 6'(i + 40), 1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
